// File: rtl/hier_stage_sched_if.sv
// Request/response handshake bundle between requesters and the shared-stage scheduler.
// The master side belongs to the requesters and the response consumer; the slave side belongs to the scheduler.
interface hier_stage_sched_if #(
  parameter int NREQ = 3,
  parameter int W    = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_ready;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/hier_stage_sched.sv
// Round-robin scheduler that time-shares one external compute stage among NREQ requesters.
// One request is in flight at a time: it is accepted, waits LAT cycles, and is then answered.
module hier_stage_sched #(
  parameter int NREQ = 3,
  parameter int W    = 3,
  parameter int LAT  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  hier_stage_sched_if.slave   bus,
  output logic [W-1:0]        stage_x,
  input  logic [W-1:0]        stage_y,
  output logic                busy,
  output logic [7:0]          done_cnt
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);
  localparam logic [1:0]       PTR_INIT = 2'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       gnt;
  logic [CNT_W-1:0] cnt;
  logic             any_req;

  // Scanning from the farthest slot down to ptr+1 leaves the nearest valid requester selected.
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] v, input logic [1:0] p);
    logic [1:0] sel;
    int         idx;
    sel = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(p) + k) % NREQ;
      if (v[idx]) sel = 2'(idx);
    end
    return sel;
  endfunction

  assign any_req = |bus.req_valid;
  assign gnt     = rr_pick(bus.req_valid, ptr);
  assign busy    = (state != IDLE);

  always_comb begin
    bus.req_ready = '0;
    if (rst_n && (state == IDLE) && any_req) bus.req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= PTR_INIT;
      cnt           <= '0;
      stage_x       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
      done_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            stage_x    <= bus.req_data[gnt*W +: W];
            bus.rsp_id <= gnt;
            cnt        <= CNT_INIT;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            bus.rsp_data  <= stage_y;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          // Response is frozen until taken; stage_y is ignored here.
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            ptr           <= bus.rsp_id;
            done_cnt      <= done_cnt + 8'd1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hier_stage_sched.md
# hier_stage_sched

Round-robin scheduler that shares one external 3-bit compute stage among `NREQ` requesters. The compute stage is the match-and-increment datapath used in the module-hierarchy tests. The block accepts one request at a time and drives its operand onto the stage. After a fixed `LAT` cycles it samples the stage result and returns it with the requester ID over a valid/ready response port. It sits between the requesting top-level logic and the stage instance, and is the only driver of the stage's input.

## Interface
- `NREQ`, default 3: number of requesters, 2..4.
- `W`, default 3: operand/result width.
- `LAT`, default 2: cycles from `stage_x` update to `stage_y` sample, ≥1.
- `clk` in 1: rising-edge clock, the only clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in `NREQ`: per-requester request valid.
- `req_data` in `NREQ*W`: operand; requester i occupies bits `[i*W +: W]`.
- `req_ready` out `NREQ`: one-hot grant/accept.
- `stage_x` out `W`: registered operand to the compute stage.
- `stage_y` in `W`: compute stage result.
- `rsp_valid` out 1: response valid.
- `rsp_id` out 2: ID of the requester being answered.
- `rsp_data` out `W`: sampled `stage_y`.
- `rsp_ready` in 1: response consumer ready.
- `busy` out 1: high in any state other than IDLE.
- `done_cnt` out 8: count of completed responses, wraps 255→0.

## Operation
States are IDLE, WAIT and RESP.

**IDLE**
- If any `req_valid` is high, the grant `g` is the first valid requester after `ptr`, searching cyclically upward.
- `req_ready[g]` is asserted combinationally in this cycle only; no other `req_ready` bit is high.
- On the clock edge:
  - `stage_x` ← `req_data[g]`.
  - `rsp_id` ← `g`.
  - `cnt` ← `LAT-1`.
  - State → WAIT.
- If no request is valid, the block stays in IDLE and all `req_ready` bits are 0.

**WAIT**
- `req_ready` is all zero.
- If `cnt != 0`, `cnt` decrements.
- If `cnt == 0`, `rsp_data` ← `stage_y`, `rsp_valid` ← 1, state → RESP.

**RESP**
- `rsp_valid`, `rsp_id` and `rsp_data` are held stable until `rsp_ready` is high.
- On the edge where `rsp_valid && rsp_ready`:
  - `rsp_valid` ← 0.
  - `ptr` ← `rsp_id`.
  - `done_cnt` ← `done_cnt + 1` (mod 256).
  - State → IDLE.
- `stage_x` holds its value until the next accept.

**Requester-side rules**
- A requester that drops `req_valid` without a grant loses nothing; there is no queueing.
- A `req_valid` held high during WAIT or RESP is not accepted until the next IDLE cycle.

**Arithmetic and width**
- `rsp_id` is zero-extended to 2 bits.
- `stage_x` and `rsp_data` are exactly `W` bits and never truncated internally.

## Timing
- **Reset values** (while `rst_n` is low):
  - State = IDLE, `ptr` = `NREQ-1`, so requester 0 wins first.
  - `stage_x` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `done_cnt` = 0, `busy` = 0.
  - `req_ready` is forced to 0 while `rst_n` is low.
- **Latency:** accept at edge A, `stage_x` valid after A, `stage_y` sampled at edge A+`LAT`, `rsp_valid` high from A+`LAT`.
- **Throughput:** with `rsp_ready` held high, one transaction every `LAT+2` cycles (IDLE, `LAT` × WAIT, RESP).
- **Simultaneous requests:** exactly one is granted per IDLE cycle, in round-robin order from `ptr+1`.
- **`rsp_ready` low:** the block stalls in RESP indefinitely with outputs stable; `stage_y` changes are ignored.
- **Reset mid-transaction:** the transaction is aborted immediately. No response is produced, `done_cnt` is not incremented, and after release the block is in IDLE with `ptr` = `NREQ-1`.
- **`rst_n` deassertion:** the first possible accept is the first rising edge with `rst_n` high.

## Test plan
Defaults throughout (`NREQ`=3, `W`=3, `LAT`=2). The bench stage model is `stage_y = (stage_x==3'b100) ? stage_x+1 : 3'b000`.

1. Single request: `req_valid`=001, `req_data[0]`=3'b100, `rsp_ready`=1 → `req_ready`=001 for one cycle. `stage_x`=3'b100. `rsp_valid` high 2 cycles after the accept with `rsp_id`=0, `rsp_data`=3'b101. `done_cnt`=1.
2. Non-matching operand: requester 1 with 3'b011 → `rsp_id`=1, `rsp_data`=3'b000.
3. Round-robin: `req_valid`=111 held, `rsp_ready`=1 → grants in order 0,1,2,0. Accepts are 4 cycles apart. `busy` is low only in the IDLE cycles.
4. Back-pressure: `rsp_ready`=0 for 5 cycles in RESP while `stage_x` is changed by forcing → `rsp_data`, `rsp_id` and `rsp_valid` are unchanged. No new `req_ready` is issued. Completion happens on the first `rsp_ready`=1 edge.
5. Reset mid-WAIT: pull `rst_n` low one cycle after an accept → all outputs return to reset values asynchronously. After release, a request with `req_valid`=110 is granted to requester 1.
6. Counter wrap: complete 256 transactions → `done_cnt` reads 255, then 0.
